// File: rtl/serial_frame_tx_pkg.sv
// Shared types for the serial frame transmitter: FSM state encoding and the
// shift-register action codes (same encoding as the upstream universal shift register).
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ShiftHold = 2'b00,
        ShiftShr  = 2'b01,
        ShiftShl  = 2'b10,
        ShiftLoad = 2'b11
    } shift_op_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_tx_bit_period_divider.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each bit period.
module serial_frame_tx_bit_period_divider
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CntW = cnt_width(DIV);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LastCnt);

    // Wrap at the end of each bit so consecutive bit periods chain without a gap.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, N data bits LSB first,
// optional even parity, stop bit; each bit held for DIV clocks.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned DIV       = 4,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int unsigned BitW = cnt_width(N);
    localparam logic [BitW-1:0] LastBit = BitW'(N - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
    logic            parity_q, parity_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    shift_op_e       shift_op;
    logic            bit_end;

    // The divider is held at zero while idle so START always gets a full period.
    serial_frame_tx_bit_period_divider #(
        .DIV (DIV)
    ) u_divider (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == StIdle),
        .bit_end (bit_end)
    );

    // Next-state, shift action, bit counter, parity capture and done pulse.
    always_comb begin
        state_d   = state_q;
        shift_op  = ShiftHold;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_op  = ShiftLoad;
                    parity_d  = ^in_data;
                    bit_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_op = ShiftShr;
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Shift register datapath.
    always_comb begin
        shift_d = shift_q;
        unique case (shift_op)
            ShiftHold: shift_d = shift_q;
            ShiftShr:  shift_d = shift_q >> 1;
            ShiftShl:  shift_d = shift_q << 1;
            ShiftLoad: shift_d = in_data;
            default:   shift_d = shift_q;
        endcase
    end

    // Registered line value follows the state being entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        unique case (state_d)
            StIdle:   tx_d = 1'b1;
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            StStop:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two builds (DIV=4 with parity, DIV=1 without),
// a cycle-queue frame model per build, and directed frames with literal expectations.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       va = 1'b0, vb = 1'b0;
    logic [3:0] da = 4'h0, db = 4'h0;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_frame_tx #(.N(4), .DIV(4), .PARITY_EN(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(va), .in_data(da),
        .in_ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    serial_frame_tx #(.N(4), .DIV(1), .PARITY_EN(0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(vb), .in_data(db),
        .in_ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: per-cycle expectations in a queue ----------------
    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } obs_t;

    localparam obs_t IdleObs = 3'b100;

    obs_t qa[$];
    obs_t qb[$];
    obs_t ea = IdleObs;
    obs_t eb = IdleObs;

    // Frame bit k: start, data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [3:0] d, input bit par, input int k);
        if (k == 0) return 1'b0;
        if (k <= 4) return d[k-1];
        if (par && k == 5) return ^d;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            qa.delete();
            qb.delete();
            ea = IdleObs;
            eb = IdleObs;
        end else begin
            if (!ea.busy && va) begin
                for (int k = 0; k < 7; k++)
                    for (int c = 0; c < 4; c++) qa.push_back({frame_bit(da, 1'b1, k), 2'b10});
                qa.push_back(3'b101);
            end
            if (!eb.busy && vb) begin
                for (int k = 0; k < 6; k++) qb.push_back({frame_bit(db, 1'b0, k), 2'b10});
                qb.push_back(3'b101);
            end
            ea = (qa.size() != 0) ? qa.pop_front() : IdleObs;
            eb = (qb.size() != 0) ? qb.pop_front() : IdleObs;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_tx", tx_a, ea.tx);
            check("a_busy", busy_a, ea.busy);
            check("a_done", done_a, ea.done);
            check("a_in_ready", ready_a, !ea.busy);
            check("b_tx", tx_b, eb.tx);
            check("b_busy", busy_b, eb.busy);
            check("b_done", done_b, eb.done);
            check("b_in_ready", ready_b, !eb.busy);
        end
    end

    // ---------------- directed stimulus ----------------
    // One frame on build A; pat lists the 7 frame bits, first bit at the MSB.
    task automatic frame_a(input logic [3:0] d, input logic [6:0] pat, input string name);
        logic [27:0] got_tx, exp_tx;
        int busy_n, done_at;
        va = 1'b1;
        da = d;
        @(negedge clk);
        va = 1'b0;
        da = ~d;
        busy_n = 0;
        done_at = 0;
        for (int c = 1; c <= 32; c++) begin
            if (c <= 28) begin
                got_tx[28-c] = tx_a;
                exp_tx[28-c] = pat[6-(c-1)/4];
            end
            if (busy_a) busy_n++;
            if (done_a && done_at == 0) done_at = c;
            if (c == 29) check({name, "_ready_after"}, ready_a, 1);
            if (c < 32) @(negedge clk);
        end
        check({name, "_tx_trace"}, got_tx, exp_tx);
        check({name, "_busy_cycles"}, busy_n, 28);
        check({name, "_done_cycle"}, done_at, 29);
    endtask

    initial begin
        int n;
        logic [5:0] got_b;
        int done_b_at;

        // Reset and idle.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_tx", tx_a, 1);
        check("reset_in_ready", ready_a, 1);
        check("reset_busy", busy_a, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Single frames.
        frame_a(4'b1010, 7'b0010101, "f1010");
        frame_a(4'b0111, 7'b0111011, "f0111");

        // Back-to-back with in_valid held high.
        va = 1'b1;
        da = 4'b0001;
        @(negedge clk);
        check("b2b_accept1", busy_a, 1);
        da = 4'b1000;
        n = 0;
        while (!done_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done1_seen", done_a, 1);
        check("b2b_len1", n, 28);
        check("b2b_gap_tx", tx_a, 1);
        check("b2b_gap_ready", ready_a, 1);
        @(negedge clk);
        va = 1'b0;
        check("b2b_start2_tx", tx_a, 0);
        check("b2b_start2_busy", busy_a, 1);
        n = 0;
        while (!done_a && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done2_seen", done_a, 1);
        check("b2b_len2", n, 28);
        repeat (3) @(negedge clk);

        // Reset during the second data bit.
        va = 1'b1;
        da = 4'b1111;
        @(negedge clk);
        va = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_tx", tx_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_ready", ready_a, 1);
        check("midrst_done", done_a, 0);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_a) n++;
        end
        check("midrst_no_done", n, 0);
        frame_a(4'b0101, 7'b0101001, "f0101");

        // Reset wins over a simultaneous valid word.
        reset = 1'b1;
        va = 1'b1;
        da = 4'b1010;
        @(negedge clk);
        reset = 1'b0;
        va = 1'b0;
        check("rst_vs_valid_busy", busy_a, 0);
        check("rst_vs_valid_tx", tx_a, 1);
        repeat (2) @(negedge clk);

        // DIV=1, no parity build.
        vb = 1'b1;
        db = 4'b1100;
        @(negedge clk);
        vb = 1'b0;
        db = 4'b0011;
        done_b_at = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 6) got_b[6-c] = tx_b;
            if (done_b && done_b_at == 0) done_b_at = c;
            @(negedge clk);
        end
        check("b1100_tx_trace", got_b, 6'b000111);
        check("b1100_done_cycle", done_b_at, 7);

        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
